writeback_queue: RTL

- Sits directly upstream of the superscalar register file, which has two write ports and four read ports; R0 is hardwired to zero.
- Collects up to two completed results per cycle from the execute stage and buffers them in program order.
- Drives both register-file write ports, issuing at most two writes per cycle.
- Never issues two writes to the same register in one cycle, because dual-port priority on a register is undefined.
- Exports a pending-write mask that the operand-read stage uses for hazard checks.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo_2w2r.sv | 65 ++++++
 rtl/writeback_queue.sv | 103 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
//   DATA_W / ADDR_W : result data width and register address width
//   NUM_REGS        : number of architectural registers (R0 hardwired to zero)
//   wb_entry_t      : one queued result {addr, data}
//   reg_onehot      : one-hot decode of a register address
package wb_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo_2w2r.sv
// Circular buffer with two write lanes and two read lanes.
//   clock, reset      : clock, async active-low reset
//   push_n            : entries written this edge (0..2); push0 first, then push1
//   pop_n             : entries removed from the head this edge (0..2)
//   head0, head1      : oldest and second-oldest entries (valid per count)
//   slot_valid        : per-slot occupancy
//   slot_addr         : destination address held in each slot
//   count             : occupied entries, 0..DEPTH
module wb_fifo_2w2r
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             push_n,
  input  wb_entry_t              push0,
  input  wb_entry_t              push1,
  input  logic [1:0]             pop_n,
  output wb_entry_t              head0,
  output wb_entry_t              head1,
  output logic [DEPTH-1:0]       slot_valid,
  output logic [ADDR_W-1:0]      slot_addr [DEPTH],
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Storage needs no reset: occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_n != 2'd0) mem[wr_ptr] <= push0;
    if (push_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push1;
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_W'(1)];

  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = PTR_W'(i) - rd_ptr;
      slot_valid[i] = CNT_W'(off) < count;
      slot_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback buffer feeding a two-write-port register file.
//   clock, reset                     : clock, async active-low reset
//   in0_* / in1_*                    : up to two results per cycle, in0 older
//   in_ready                         : room for two results this cycle
//   wr_en0/addr0/data0, wr_en1/...   : registered register-file write ports
//   pending                          : registers with a write queued or on a port
//   count                            : occupied queue entries
// DATA_W / ADDR_W must match the widths in wb_pkg, which sizes the stored entries.
module writeback_queue #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in0_valid,
  input  logic [ADDR_W-1:0]      in0_addr,
  input  logic [DATA_W-1:0]      in0_data,
  input  logic                   in1_valid,
  input  logic [ADDR_W-1:0]      in1_addr,
  input  logic [DATA_W-1:0]      in1_data,
  output logic                   in_ready,
  output logic                   wr_en0,
  output logic [ADDR_W-1:0]      wr_addr0,
  output logic [DATA_W-1:0]      wr_data0,
  output logic                   wr_en1,
  output logic [ADDR_W-1:0]      wr_addr1,
  output logic [DATA_W-1:0]      wr_data1,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  wb_pkg::wb_entry_t in0_e, in1_e, push0, push1, head0, head1;
  logic [ADDR_W-1:0] slot_addr [DEPTH];
  logic [DEPTH-1:0]  slot_valid;
  logic [1:0]        push_n, pop_n;
  logic              v0, v1, h0_valid, pair_ok;

  assign in_ready = reset && (count <= CNT_W'(DEPTH - 2));

  // Writes to R0 have no architectural effect, so they never take a slot.
  assign v0     = in0_valid && (in0_addr != '0);
  assign v1     = in1_valid && (in1_addr != '0);
  assign in0_e  = '{addr: in0_addr, data: in0_data};
  assign in1_e  = '{addr: in1_addr, data: in1_data};
  assign push_n = in_ready ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
  // Compact so a lone surviving result always lands in the first lane.
  assign push0  = v0 ? in0_e : in1_e;
  assign push1  = in1_e;

  // Same-address pair would hit undefined dual-port priority; issue the older one alone.
  assign h0_valid = (count != '0);
  assign pair_ok  = (count > CNT_W'(1)) && (head1.addr != head0.addr);
  assign pop_n    = !h0_valid ? 2'd0 : (pair_ok ? 2'd2 : 2'd1);

  wb_fifo_2w2r #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_n     (push_n),
    .push0      (push0),
    .push1      (push1),
    .pop_n      (pop_n),
    .head0      (head0),
    .head1      (head1),
    .slot_valid (slot_valid),
    .slot_addr  (slot_addr),
    .count      (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en0   <= 1'b0;
      wr_addr0 <= '0;
      wr_data0 <= '0;
      wr_en1   <= 1'b0;
      wr_addr1 <= '0;
      wr_data1 <= '0;
    end else begin
      wr_en0   <= h0_valid;
      wr_addr0 <= h0_valid ? head0.addr : '0;
      wr_data0 <= h0_valid ? head0.data : '0;
      wr_en1   <= pair_ok;
      wr_addr1 <= pair_ok ? head1.addr : '0;
      wr_data1 <= pair_ok ? head1.data : '0;
    end
  end

  always_comb begin
    logic [NUM_REGS-1:0] p;
    p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) p = p | wb_pkg::reg_onehot(slot_addr[i]);
    end
    if (wr_en0) p = p | wb_pkg::reg_onehot(wr_addr0);
    if (wr_en1) p = p | wb_pkg::reg_onehot(wr_addr1);
    p[0]    = 1'b0;
    pending = p;
  end

endmodule
